// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the dmem_bank data memory slice:
//   size_e  - access size encoding carried on i_size (2'b11 is not a legal size)
//   state_e - zero-fill controller states
//   RD_LAT_MIN / RD_LAT_MAX - legal range of the request-to-response latency
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dmem_align.sv
// dmem_align
// Purely combinational lane logic for the data memory.
//   req_size, req_offset : size and addr[1:0] of the incoming request
//   st_data              : right-justified store data
//   st_mask, st_lanes    : byte enables and lane-shifted store data
//   misaligned           : request violates natural alignment or uses size 2'b11
//   ld_size, ld_offset,
//   ld_unsigned          : attributes of the load whose RAM word is in ld_word
//   ld_word              : raw 32-bit word read from the array
//   ld_data              : selected bytes, zero- or sign-extended to 32 bits
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] st_lanes,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [4:0]  st_shift;
    logic [15:0] ld_lane;

    assign st_shift = {req_offset, 3'b000};

    // Only the low halfword of the shifted word is ever needed: word loads
    // bypass the shifter entirely.
    assign ld_lane = 16'(ld_word >> {ld_offset, 3'b000});

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_offset[0];
            SZ_WORD: misaligned = (req_offset != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Misaligned halves still produce a mask here; the top suppresses the
    // write through the error flag, so no extra gating is needed.
    always_comb begin
        st_mask  = 4'b0000;
        st_lanes = 32'h0000_0000;
        case (req_size)
            SZ_BYTE: begin
                st_mask  = 4'b0001 << req_offset;
                st_lanes = {24'h00_0000, st_data[7:0]} << st_shift;
            end
            SZ_HALF: begin
                st_mask  = 4'b0011 << req_offset;
                st_lanes = {16'h0000, st_data[15:0]} << st_shift;
            end
            SZ_WORD: begin
                st_mask  = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                st_mask  = 4'b0000;
                st_lanes = 32'h0000_0000;
            end
        endcase
    end

    always_comb begin
        ld_data = 32'h0000_0000;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h00_0000, ld_lane[7:0]}
                                           : {{24{ld_lane[7]}}, ld_lane[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0000, ld_lane}
                                           : {{16{ld_lane[15]}}, ld_lane};
            SZ_WORD: ld_data = ld_word;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_bank.sv
// dmem_bank
// Byte-addressed data memory bank with sized loads/stores, a fixed-latency
// response pipeline and a whole-array zero fill.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_req_valid      : request present; accepted when o_req_ready is also high
//   o_req_ready      : bank can take a request this cycle
//   i_wren           : 1 = store, 0 = load
//   i_addr           : byte address
//   i_wdata          : right-justified store data
//   i_size           : 00 byte, 01 half, 10 word, 11 always misaligned
//   i_unsigned       : zero-extend (1) or sign-extend (0) loads
//   i_clr            : pulse starting a zero fill of every word
//   o_busy           : zero fill in progress
//   o_rsp_valid      : one-cycle response strobe, RD_LAT cycles after acceptance
//   o_rdata          : extended load data, 0 for stores and errors
//   o_rsp_err        : the answered request was misaligned or out of range
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH_WORDS = 512,
    parameter int    RD_LAT      = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state;
    logic [IDX_W-1:0]   clr_cnt;

    logic               accept;
    logic               clearing;
    logic [IDX_W-1:0]   req_idx;
    logic               out_of_range;
    logic               misaligned;
    logic               req_err;

    logic [3:0]         st_mask;
    logic [31:0]        st_lanes;

    logic               mem_we;
    logic               mem_re;
    logic [3:0]         mem_be;
    logic [IDX_W-1:0]   mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        ram_q;

    logic               s1_valid;
    logic               s1_err;
    logic               s1_load;
    logic [1:0]         s1_size;
    logic [1:0]         s1_offset;
    logic               s1_unsigned;
    logic [31:0]        ld_data;
    logic [31:0]        rsp_data;

    // Reset is folded into ready so nothing presented during reset is taken.
    assign o_req_ready = (state == ST_IDLE) && !i_clr && !i_reset;
    assign accept      = i_req_valid && o_req_ready;
    assign clearing    = (state == ST_CLEAR) && !i_reset;

    // Any address bit above the array's word index means out of range.
    assign req_idx      = i_addr[IDX_W+1:2];
    assign out_of_range = |(i_addr >> (IDX_W + 2));
    assign req_err      = misaligned || out_of_range;

    dmem_align u_align (
        .req_size    (i_size),
        .req_offset  (i_addr[1:0]),
        .st_data     (i_wdata),
        .st_mask     (st_mask),
        .st_lanes    (st_lanes),
        .misaligned  (misaligned),
        .ld_size     (s1_size),
        .ld_offset   (s1_offset),
        .ld_unsigned (s1_unsigned),
        .ld_word     (ram_q),
        .ld_data     (ld_data)
    );

    // Single RAM port shared between the zero-fill walker and requests;
    // they never overlap because ready is low throughout a fill.
    assign mem_we    = clearing || (accept && i_wren && !req_err);
    assign mem_re    = accept && !i_wren && !req_err;
    assign mem_be    = clearing ? 4'b1111 : st_mask;
    assign mem_addr  = clearing ? clr_cnt : req_idx;
    assign mem_wdata = clearing ? 32'h0000_0000 : st_lanes;

    // Byte-enabled synchronous-read RAM; no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_re) begin
            ram_q <= mem[mem_addr];
        end
    end

    // Zero-fill controller; the counter wraps back to 0 on the last word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_clr) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // First response stage, aligned with the RAM read register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_load  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && req_err;
            s1_load  <= mem_re;
        end
        if (accept) begin
            s1_size     <= i_size;
            s1_offset   <= i_addr[1:0];
            s1_unsigned <= i_unsigned;
        end
    end

    assign rsp_data = s1_load ? ld_data : 32'h0000_0000;

    // With one cycle of latency the outputs come straight from stage-one
    // flops and the RAM register; a second cycle adds a full output register.
    if (RD_LAT <= RD_LAT_MIN) begin : g_lat1
        assign o_rsp_valid = s1_valid;
        assign o_rsp_err   = s1_err;
        assign o_rdata     = rsp_data;
    end else begin : g_lat2
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                o_rsp_valid <= 1'b0;
                o_rsp_err   <= 1'b0;
                o_rdata     <= 32'h0000_0000;
            end else begin
                o_rsp_valid <= s1_valid;
                o_rsp_err   <= s1_err;
                o_rdata     <= rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank
// Drives two dmem_bank instances (RD_LAT=1 and RD_LAT=2) with identical
// stimulus. Each accepted request pushes its expected response, with the
// cycle it is due, onto a per-instance queue; a negedge monitor pops and
// compares whenever a response strobe appears or an entry becomes overdue.
module tb_dmem_bank;
    import dmem_pkg::*;

    localparam int DEPTH = 512;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        clr;

    logic        readyA, busyA, validA, errA;
    logic [31:0] rdataA;
    logic        readyB, busyB, validB, errB;
    logic [31:0] rdataB;

    int   cycleCount = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t expQ[2][$];
    int   busyCntA;
    int   busyCntB;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    dmem_bank #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .INIT_FILE("")) dutA (
        .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(readyA),
        .i_wren(wren), .i_addr(addr), .i_wdata(wdata), .i_size(size),
        .i_unsigned(uns), .i_clr(clr), .o_busy(busyA), .o_rsp_valid(validA),
        .o_rdata(rdataA), .o_rsp_err(errA)
    );

    dmem_bank #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LAT(2), .INIT_FILE("")) dutB (
        .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(readyB),
        .i_wren(wren), .i_addr(addr), .i_wdata(wdata), .i_size(size),
        .i_unsigned(uns), .i_clr(clr), .o_busy(busyB), .o_rsp_valid(validB),
        .o_rdata(rdataB), .o_rsp_err(errB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Compare one instance's response port against the head of its queue.
    task automatic scoreTick(input int k, input logic v, input logic [31:0] d, input logic e);
        exp_t front;
        string name;
        name = (k == 0) ? "A" : "B";
        if (v === 1'b1) begin
            if (expQ[k].size() == 0) begin
                checkOutput({name, " spurious rsp_valid"}, 32'(v), 32'h0);
            end else begin
                front = expQ[k].pop_front();
                checkOutput({name, " rsp cycle"}, 32'(cycleCount), 32'(front.due));
                checkOutput({name, " rdata"}, d, front.data);
                checkOutput({name, " rsp_err"}, 32'(e), 32'(front.err));
            end
        end else if (expQ[k].size() != 0 && expQ[k][0].due < cycleCount) begin
            front = expQ[k].pop_front();
            checkOutput({name, " missing rsp_valid"}, 32'(v), 32'h1);
        end
    endtask

    always @(negedge clk) begin
        scoreTick(0, validA, rdataA, errA);
        scoreTick(1, validB, rdataB, errB);
    end

    // Called just after a rising edge; presents one request for a cycle and
    // records what each instance must answer and when.
    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, input bit u,
                                 input logic [31:0] expData, input bit expErr,
                                 input bit [1:0] pushMask = 2'b11);
        int c;
        reqValid = 1'b1;
        wren     = w;
        addr     = a;
        wdata    = d;
        size     = sz;
        uns      = u;
        #1;
        checkOutput("A ready", 32'(readyA), 32'h1);
        checkOutput("B ready", 32'(readyB), 32'h1);
        c = cycleCount;
        if (pushMask[0]) expQ[0].push_back('{data: expData, err: expErr, due: c + 1});
        if (pushMask[1]) expQ[1].push_back('{data: expData, err: expErr, due: c + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        reqValid = 1'b0;
        clr      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        reqValid = 1'b0;
        wren     = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        size     = SZ_WORD;
        uns      = 1'b0;
        clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, including ready held low while reset is asserted
        checkOutput("A rsp_valid at reset", 32'(validA), 32'h0);
        checkOutput("B rsp_valid at reset", 32'(validB), 32'h0);
        checkOutput("A busy at reset", 32'(busyA), 32'h0);
        checkOutput("B busy at reset", 32'(busyB), 32'h0);
        checkOutput("A rdata at reset", rdataA, 32'h0);
        checkOutput("B rdata at reset", rdataB, 32'h0);
        checkOutput("A err at reset", 32'(errA), 32'h0);
        checkOutput("B err at reset", 32'(errB), 32'h0);
        checkOutput("A ready in reset", 32'(readyA), 32'h0);
        checkOutput("B ready in reset", 32'(readyB), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Word store/load and back-to-back read-after-write
        applyStimulus(1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0, 0);
        applyStimulus(0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEADBEEF, 0);
        // Byte store and signed/unsigned byte loads
        applyStimulus(1, 32'h13, 32'h00000080, SZ_BYTE, 0, 32'h0, 0);
        applyStimulus(0, 32'h13, 32'h0, SZ_BYTE, 0, 32'hFFFFFF80, 0);
        applyStimulus(0, 32'h13, 32'h0, SZ_BYTE, 1, 32'h00000080, 0);
        applyStimulus(0, 32'h10, 32'h0, SZ_WORD, 0, 32'h80ADBEEF, 0);
        // Misaligned half, misaligned word store, illegal size
        applyStimulus(0, 32'h11, 32'h0, SZ_HALF, 0, 32'h0, 1);
        applyStimulus(1, 32'h12, 32'h01234567, SZ_WORD, 0, 32'h0, 1);
        applyStimulus(0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1);
        applyStimulus(0, 32'h10, 32'h0, SZ_WORD, 0, 32'h80ADBEEF, 0);
        // Out of range store must not alias onto word 0
        applyStimulus(1, 32'h0, 32'h11223344, SZ_WORD, 0, 32'h0, 0);
        applyStimulus(1, 32'h800, 32'hCAFEF00D, SZ_WORD, 0, 32'h0, 1);
        applyStimulus(0, 32'hFFFFFFFC, 32'h0, SZ_WORD, 0, 32'h0, 1);
        applyStimulus(0, 32'h0, 32'h0, SZ_WORD, 0, 32'h11223344, 0);
        // Halfword lanes and extension
        applyStimulus(1, 32'h20, 32'hFFFF8001, SZ_HALF, 0, 32'h0, 0);
        applyStimulus(1, 32'h22, 32'h00001234, SZ_HALF, 0, 32'h0, 0);
        applyStimulus(0, 32'h22, 32'h0, SZ_HALF, 0, 32'h00001234, 0);
        applyStimulus(0, 32'h20, 32'h0, SZ_HALF, 0, 32'hFFFF8001, 0);
        applyStimulus(0, 32'h20, 32'h0, SZ_HALF, 1, 32'h00008001, 0);
        applyStimulus(0, 32'h21, 32'h0, SZ_BYTE, 1, 32'h00000080, 0);
        applyStimulus(0, 32'h23, 32'h0, SZ_BYTE, 0, 32'h00000012, 0);
        applyStimulus(0, 32'h20, 32'h0, SZ_WORD, 0, 32'h12348001, 0);
        idleCycles(3);

        // Clear together with a store: the store must be refused
        reqValid = 1'b1;
        wren     = 1'b1;
        addr     = 32'h10;
        wdata    = 32'hFFFFFFFF;
        size     = SZ_WORD;
        clr      = 1'b1;
        #1;
        checkOutput("A ready with clr", 32'(readyA), 32'h0);
        checkOutput("B ready with clr", 32'(readyB), 32'h0);
        @(posedge clk);
        #1;
        clr  = 1'b0;
        wren = 1'b0;
        #1;
        checkOutput("A ready while busy", 32'(readyA), 32'h0);
        checkOutput("B ready while busy", 32'(readyB), 32'h0);
        busyCntA = 0;
        busyCntB = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reqValid = 1'b0;
            if (busyA) busyCntA++;
            if (busyB) busyCntB++;
        end
        @(posedge clk);
        #1;
        checkOutput("A busy cycles", 32'(busyCntA), 32'(DEPTH));
        checkOutput("B busy cycles", 32'(busyCntB), 32'(DEPTH));
        for (int wIdx = 0; wIdx < DEPTH; wIdx++) begin
            applyStimulus(0, 32'(wIdx * 4), 32'h0, SZ_WORD, 0, 32'h0, 0);
        end

        // Clear with a load still draining, then reset at clear cycle 100
        applyStimulus(1, 32'h7D0, 32'h12345678, SZ_WORD, 0, 32'h0, 0);
        applyStimulus(1, 32'h40, 32'h55AA55AA, SZ_WORD, 0, 32'h0, 0);
        applyStimulus(0, 32'h40, 32'h0, SZ_WORD, 0, 32'h55AA55AA, 0);
        reqValid = 1'b0;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        checkOutput("A busy before reset", 32'(busyA), 32'h1);
        checkOutput("B busy before reset", 32'(busyB), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("A busy after reset", 32'(busyA), 32'h0);
        checkOutput("B busy after reset", 32'(busyB), 32'h0);
        checkOutput("A ready after reset", 32'(readyA), 32'h1);
        checkOutput("B ready after reset", 32'(readyB), 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(0, 32'h40, 32'h0, SZ_WORD, 0, 32'h0, 0);
        applyStimulus(0, 32'h7D0, 32'h0, SZ_WORD, 0, 32'h12345678, 0);

        // Reset with a load in flight: only the one-cycle instance answers;
        // a store presented during reset must not land
        applyStimulus(0, 32'h7D0, 32'h0, SZ_WORD, 0, 32'h12345678, 0, 2'b01);
        reset = 1'b1;
        wren  = 1'b1;
        wdata = 32'hFFFFFFFF;
        #1;
        checkOutput("A ready in reset", 32'(readyA), 32'h0);
        checkOutput("B ready in reset", 32'(readyB), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(3);
        applyStimulus(0, 32'h7D0, 32'h0, SZ_WORD, 0, 32'h12345678, 0);
        idleCycles(5);
        checkOutput("A queue drained", 32'(expQ[0].size()), 32'h0);
        checkOutput("B queue drained", 32'(expQ[1].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
